// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and constants for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_DEFAULT = 1000000;

    // Channel index of the start button, used by the game core
    localparam int BTN_START_IDX = 4;

endpackage

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - one button: two-flop synchronizer, debounce FSM, press/release pulses
module button_debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
        sync1_d   = btn_n;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        // sync2_q is the synchronized active-low pin: 0 means pressed
        case (state_q)
            RELEASED: begin
                if (!sync2_q) begin
                    state_d = PRESS_PEND;
                    cnt_d   = '0;
                end
            end
            PRESS_PEND: begin
                if (sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync2_q) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = '0;
                end
            end
            RELEASE_PEND: begin
                if (!sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N_BTN independent debounce channels plus combined press indication
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic             any_press
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .btn_n         (btn_n[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

    // Pulses are already registered, so the OR adds no latency
    assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    localparam int N = 5;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_n;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         any_press;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .any_press     (any_press)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Samples n negedges; cycle 1 is the negedge right after the next posedge
    task automatic watch(input int n, input int ch,
                         output int p_cnt, output int p_at,
                         output int r_cnt, output int r_at,
                         output int any_cnt, output logic [N-1:0] p_vec,
                         output logic [127:0] lvl_hist);
        p_cnt = 0; p_at = 0; r_cnt = 0; r_at = 0; any_cnt = 0;
        p_vec = '0; lvl_hist = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            lvl_hist[i-1] = btn_level[ch];
            if (press_pulse[ch]) begin
                p_cnt++;
                if (p_at == 0) p_at = i;
            end
            if (release_pulse[ch]) begin
                r_cnt++;
                if (r_at == 0) r_at = i;
            end
            if (any_press) any_cnt++;
            if (press_pulse != '0 && p_vec == '0) p_vec = press_pulse;
        end
    endtask

    int            pc, pa, rc, ra, ac, acc, lows;
    logic [N-1:0]  pv;
    logic [127:0]  lh;

    initial begin
        reset = 1'b0;
        btn_n = 5'b00000;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("reset_outs", {btn_level, press_pulse, release_pulse, any_press},
                     32'h0);
        end
        btn_n = 5'b11111;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        watch(3, 0, pc, pa, rc, ra, ac, pv, lh);
        check_eq("idle_after_reset", {btn_level, press_pulse, release_pulse, any_press},
                 32'h0);

        // clean press / release on channel 0
        btn_n[0] = 1'b0;
        watch(20, 0, pc, pa, rc, ra, ac, pv, lh);
        check_eq("clean_press_cnt", pc, 1);
        check_eq("clean_press_at", pa, 7);
        check_eq("clean_lvl_before", lh[5], 1'b0);
        check_eq("clean_lvl_on", lh[6], 1'b1);
        check_eq("clean_lvl_held", lh[19], 1'b1);
        check_eq("clean_no_release", rc, 0);
        btn_n[0] = 1'b1;
        watch(14, 0, pc, pa, rc, ra, ac, pv, lh);
        check_eq("clean_release_cnt", rc, 1);
        check_eq("clean_release_at", ra, 7);
        check_eq("clean_rel_lvl_before", lh[5], 1'b1);
        check_eq("clean_rel_lvl_after", lh[6], 1'b0);
        check_eq("clean_rel_no_press", pc, 0);

        // bounce on channel 2
        acc = 0;
        btn_n[2] = 1'b0; watch(3, 2, pc, pa, rc, ra, ac, pv, lh); acc += pc + rc;
        btn_n[2] = 1'b1; watch(1, 2, pc, pa, rc, ra, ac, pv, lh); acc += pc + rc;
        btn_n[2] = 1'b0; watch(2, 2, pc, pa, rc, ra, ac, pv, lh); acc += pc + rc;
        btn_n[2] = 1'b1; watch(1, 2, pc, pa, rc, ra, ac, pv, lh); acc += pc + rc;
        check_eq("bounce_no_pulse", acc, 0);
        btn_n[2] = 1'b0;
        watch(15, 2, pc, pa, rc, ra, ac, pv, lh);
        check_eq("bounce_press_cnt", pc, 1);
        check_eq("bounce_press_at", pa, 7);
        btn_n = 5'b11111;
        watch(14, 2, pc, pa, rc, ra, ac, pv, lh);
        check_eq("bounce_release_cnt", rc, 1);

        // simultaneous press on channels 1 and 3
        btn_n = 5'b10101;
        watch(12, 1, pc, pa, rc, ra, ac, pv, lh);
        check_eq("simul_vec", pv, 5'b01010);
        check_eq("simul_at", pa, 7);
        check_eq("simul_any_cnt", ac, 1);
        btn_n = 5'b11111;
        watch(14, 1, pc, pa, rc, ra, ac, pv, lh);

        // long hold on channel 4
        btn_n = 5'b01111;
        watch(100, 4, pc, pa, rc, ra, ac, pv, lh);
        check_eq("hold_press_cnt", pc, 1);
        check_eq("hold_press_at", pa, 7);
        lows = 0;
        for (int i = 6; i < 100; i++) if (!lh[i]) lows++;
        check_eq("hold_level_low_cycles", lows, 0);
        btn_n = 5'b11111;
        watch(14, 4, pc, pa, rc, ra, ac, pv, lh);
        check_eq("hold_release_cnt", rc, 1);

        // reset in the middle of a press debounce on channel 0
        btn_n = 5'b11110;
        watch(4, 0, pc, pa, rc, ra, ac, pv, lh);
        check_eq("midrst_pre_pulse", pc + rc, 0);
        reset = 1'b0;
        watch(2, 0, pc, pa, rc, ra, ac, pv, lh);
        check_eq("midrst_during_pulse", pc + rc, 0);
        check_eq("midrst_during_outs", {btn_level, press_pulse, release_pulse, any_press},
                 32'h0);
        reset = 1'b1;
        watch(15, 0, pc, pa, rc, ra, ac, pv, lh);
        check_eq("midrst_press_cnt", pc, 1);
        check_eq("midrst_press_at", pa, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
